// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU scheduler and its arbiter.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned NREQ   = 2;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last_grant starts at 1 so requester 0 wins the first contention.
module rr_arb2
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] eligible,
    output logic [NREQ-1:0] grant
);

    req_id_t last_grant;

    // Favour the requester that did not win last time.
    always_comb begin
        grant = '0;
        if (eligible[0] && (!eligible[1] || last_grant == req_id_t'(1'b1))) begin
            grant[0] = 1'b1;
        end else if (eligible[1]) begin
            grant[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= req_id_t'(1'b1);
        end else if (|grant) begin
            last_grant <= req_id_t'(grant[1]);
        end
    end

endmodule

// File: rtl/alu_pipe_sched.sv
// Round-robin issue of two requesters into a shared pipelined ALU, with a tag
// pipeline that routes each result back to its originator.
module alu_pipe_sched
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [OP_W-1:0]        alu_control,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic                   alu_cout,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_cout,
    output logic                   busy
);

    localparam int unsigned NSTG  = ALU_LAT + 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0]  out_cnt [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   grant;
    tag_t              tag_q [NSTG];
    tag_t              new_tag;
    tag_t              tail;
    logic [NREQ-1:0]   rsp_valid_d;
    logic              busy_d;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;

    // Requesters are held off while in reset or when their credits are exhausted.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            eligible[i] = rst_n && req_valid[i] && (out_cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    assign req_ready = grant;

    always_comb begin
        sel_a   = grant[1] ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        sel_b   = grant[1] ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        sel_op  = grant[1] ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];
        new_tag = '{valid: |grant, id: req_id_t'(grant[1])};
        tail    = tag_q[NSTG-1];

        rsp_valid_d = '0;
        if (tail.valid) begin
            rsp_valid_d[tail.id] = 1'b1;
        end

        // busy reflects the tag/response state that will hold after this edge.
        busy_d = new_tag.valid | (|rsp_valid_d);
        for (int unsigned s = 0; s < NSTG - 1; s++) begin
            busy_d = busy_d | tag_q[s].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_cout    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (|grant) begin
                alu_a       <= sel_a;
                alu_b       <= sel_b;
                alu_control <= sel_op;
            end
            if (tail.valid) begin
                rsp_data <= alu_out;
                rsp_cout <= alu_cout;
            end
            rsp_valid <= rsp_valid_d;
            busy      <= busy_d;
        end
    end

    // Tag pipeline depth matches the ALU latency plus the operand register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NSTG; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= new_tag;
            for (int unsigned s = 1; s < NSTG; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // A grant and a retirement in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                out_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant[i] && !rsp_valid[i]) begin
                    out_cnt[i] <= out_cnt[i] + CNT_W'(1);
                end else if (!grant[i] && rsp_valid[i]) begin
                    out_cnt[i] <= out_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe_sched.sv
// Directed bench for alu_pipe_sched with a two-stage behavioural ALU attached.
module tb_alu_pipe_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [5:0]  req_op = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_control;
    logic [7:0]  alu_out = '0;
    logic        alu_cout = 1'b0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_cout;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] alu_s1 = '0;

    always #5 clk = ~clk;

    alu_pipe_sched #(.ALU_LAT(2), .MAX_OUT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_cout    (alu_cout),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_cout    (rsp_cout),
        .busy        (busy)
    );

    // ALU stand-in: 0 and, 1 or, 2 add, 3 sub (cout = borrow), others xor.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    alu_f = {1'b0, a & b};
            3'd1:    alu_f = {1'b0, a | b};
            3'd2:    alu_f = {1'b0, a} + {1'b0, b};
            3'd3:    alu_f = {1'b0, a} - {1'b0, b};
            default: alu_f = {1'b0, a ^ b};
        endcase
    endfunction

    always @(posedge clk) begin
        alu_s1              <= alu_f(alu_a, alu_b, alu_control);
        {alu_cout, alu_out} <= alu_s1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        if (i == 0) begin
            req_a[7:0] = a; req_b[7:0] = b; req_op[2:0] = op;
        end else begin
            req_a[15:8] = a; req_b[15:8] = b; req_op[5:3] = op;
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b11;
        tick();
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b exp 00", req_ready);
        else n_pass++;
        n_checks++;
        if ({alu_a, alu_b, alu_control} !== 19'd0)
            $display("FAIL reset_alu: got a=%0d b=%0d op=%0d exp 0", alu_a, alu_b, alu_control);
        else n_pass++;
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_cout, busy} !== 12'd0)
            $display("FAIL reset_rsp: got v=%b d=%0d c=%b busy=%b exp 0", rsp_valid, rsp_data, rsp_cout, busy);
        else n_pass++;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [1:0] exp_v;
        apply_reset();
        set_req(0, 8'd5, 8'd12, 3'b011);
        req_valid = 2'b01;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready);
                else n_pass++;
            end
            if (c == 1) begin
                n_checks++;
                if (alu_a !== 8'd5 || alu_b !== 8'd12 || alu_control !== 3'd3 || busy !== 1'b1)
                    $display("FAIL single_issue: got a=%0d b=%0d op=%0d busy=%b exp 5 12 3 1",
                             alu_a, alu_b, alu_control, busy);
                else n_pass++;
            end
            exp_v = (c == 4) ? 2'b01 : 2'b00;
            n_checks++;
            if (rsp_valid !== exp_v) $display("FAIL single_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_v);
            else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (rsp_data !== 8'hF9 || rsp_cout !== 1'b1)
                    $display("FAIL single_rsp_data: got %0d/%b exp 249/1", rsp_data, rsp_cout);
                else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b exp 0", busy);
                else n_pass++;
            end
            tick();
            req_valid = '0;
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_r;
        logic [1:0] exp_v;
        logic [7:0] exp_d;
        apply_reset();
        set_req(0, 8'd7, 8'd12, 3'd1);
        set_req(1, 8'd6, 8'd10, 3'd0);
        for (int c = 0; c <= 8; c++) begin
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            @(negedge clk);
            exp_r = (c < 4) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_checks++;
            if (req_ready !== exp_r) $display("FAIL cont_ready c%0d: got %b exp %b", c, req_ready, exp_r);
            else n_pass++;
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (alu_control !== ((c % 2 == 1) ? 3'd1 : 3'd0))
                    $display("FAIL cont_alu_op c%0d: got %0d", c, alu_control);
                else n_pass++;
            end
            exp_v = (c >= 4 && c <= 7) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_checks++;
            if (rsp_valid !== exp_v) $display("FAIL cont_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_v);
            else n_pass++;
            if (c >= 4 && c <= 7) begin
                exp_d = (c % 2 == 0) ? 8'd15 : 8'd2;
                n_checks++;
                if (rsp_data !== exp_d || rsp_cout !== 1'b0)
                    $display("FAIL cont_rsp_data c%0d: got %0d/%b exp %0d/0", c, rsp_data, rsp_cout, exp_d);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_credit;
        logic [1:0] exp_r;
        apply_reset();
        set_req(0, 8'd1, 8'd2, 3'd2);
        req_valid = 2'b01;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            exp_r = (c < 3 || c == 5) ? 2'b01 : 2'b00;
            n_checks++;
            if (req_ready !== exp_r) $display("FAIL credit_ready c%0d: got %b exp %b", c, req_ready, exp_r);
            else n_pass++;
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic test_bubbles;
        logic [1:0] exp_v;
        int pulses;
        pulses = 0;
        apply_reset();
        for (int c = 0; c <= 9; c++) begin
            if (c == 0) begin
                set_req(1, 8'd9, 8'd4, 3'd2);
                req_valid = 2'b10;
            end else if (c == 3) begin
                set_req(1, 8'd20, 8'd30, 3'd1);
                req_valid = 2'b10;
            end else begin
                req_valid = 2'b00;
            end
            @(negedge clk);
            if (rsp_valid[1]) pulses++;
            exp_v = (c == 4 || c == 7) ? 2'b10 : 2'b00;
            n_checks++;
            if (rsp_valid !== exp_v) $display("FAIL bub_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_v);
            else n_pass++;
            if (c == 4 || c == 7) begin
                n_checks++;
                if (rsp_data !== ((c == 4) ? 8'd13 : 8'd30))
                    $display("FAIL bub_rsp_data c%0d: got %0d", c, rsp_data);
                else n_pass++;
            end
            if (c == 2) begin
                n_checks++;
                if (alu_a !== 8'd9 || alu_b !== 8'd4 || alu_control !== 3'd2)
                    $display("FAIL bub_hold1: got %0d %0d %0d exp 9 4 2", alu_a, alu_b, alu_control);
                else n_pass++;
            end
            if (c == 9) begin
                n_checks++;
                if (alu_a !== 8'd20 || alu_b !== 8'd30 || alu_control !== 3'd1)
                    $display("FAIL bub_hold2: got %0d %0d %0d exp 20 30 1", alu_a, alu_b, alu_control);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (pulses !== 2) $display("FAIL bub_pulses: got %0d exp 2", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_midflight;
        logic [1:0] exp_r;
        set_req(1, 8'd3, 8'd3, 3'd2);
        set_req(0, 8'd4, 8'd4, 3'd2);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b exp 1", busy);
        else n_pass++;
        tick();
        req_valid = 2'b01;
        tick();
        rst_n = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00) $display("FAIL mid_ready_in_reset: got %b exp 00", req_ready);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        req_valid = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0)
                $display("FAIL mid_quiet c%0d: got v=%b busy=%b exp 00 0", c, rsp_valid, busy);
            else n_pass++;
            tick();
        end
        for (int c = 0; c <= 3; c++) begin
            req_valid = (c == 0) ? 2'b11 : 2'b10;
            @(negedge clk);
            exp_r = (c == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (req_ready !== exp_r) $display("FAIL mid_after_ready c%0d: got %b exp %b", c, req_ready, exp_r);
            else n_pass++;
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 8; c++) tick();
    endtask

    task automatic test_carry;
        logic [1:0] exp_v;
        set_req(0, 8'd200, 8'd100, 3'd2);
        req_valid = 2'b01;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            exp_v = (c == 4) ? 2'b01 : 2'b00;
            n_checks++;
            if (rsp_valid !== exp_v) $display("FAIL carry_rsp_valid c%0d: got %b exp %b", c, rsp_valid, exp_v);
            else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (rsp_data !== 8'd44 || rsp_cout !== 1'b1)
                    $display("FAIL carry_rsp_data: got %0d/%b exp 44/1", rsp_data, rsp_cout);
                else n_pass++;
            end
            tick();
            req_valid = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_credit();
        test_bubbles();
        test_reset_midflight();
        test_carry();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
